// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for PONG; gates paddles/ball, scores misses, picks serve direction, declares winner
//   i_Clk           system clock (pixel clock domain)
//   i_Rst_n         asynchronous active-low reset
//   i_start         start/restart button level (debounced)
//   i_miss_left     1-cycle pulse, ball passed left edge (right player scores)
//   i_miss_right    1-cycle pulse, ball passed right edge (left player scores)
//   o_paddle_enable paddle enable, 0 holds paddles at centre
//   o_ball_enable   ball enable, 0 holds ball at centre
//   o_serve_dir     0 serve toward left player, 1 toward right player
//   o_score_left    left player score
//   o_score_right   right player score
//   o_winner        00 none, 01 left, 10 right
//   o_state         FSM state encoding
module pong_match_ctrl #(
    parameter int SERVE_DELAY_CYCLES = 25_000_000,
    parameter int POINT_HOLD_CYCLES  = 50_000_000,
    parameter int WIN_SCORE          = 7,
    parameter int SCORE_W            = 4
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_start,
    input  logic               i_miss_left,
    input  logic               i_miss_right,
    output logic               o_paddle_enable,
    output logic               o_ball_enable,
    output logic               o_serve_dir,
    output logic [SCORE_W-1:0] o_score_left,
    output logic [SCORE_W-1:0] o_score_right,
    output logic [1:0]         o_winner,
    output logic [2:0]         o_state
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [31:0]        SERVE_LAST = 32'(SERVE_DELAY_CYCLES - 1);
    localparam logic [31:0]        POINT_LAST = 32'(POINT_HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    state_t             state, state_nxt;
    logic [31:0]        cnt, cnt_nxt;
    logic [SCORE_W-1:0] sl_nxt, sr_nxt, sl_inc, sr_inc;
    logic [1:0]         win_nxt;
    logic               dir_nxt, start_q, start_edge, state_ok;

    assign start_edge = i_start & ~start_q;
    assign sl_inc     = o_score_left + SCORE_W'(1);
    assign sr_inc     = o_score_right + SCORE_W'(1);
    assign state_ok   = state inside {IDLE, SERVE, PLAY, POINT, GAME_OVER};
    assign o_state    = state;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            start_q         <= 1'b1;
            o_score_left    <= '0;
            o_score_right   <= '0;
            o_winner        <= 2'b00;
            o_serve_dir     <= 1'b0;
            o_paddle_enable <= 1'b0;
            o_ball_enable   <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            start_q         <= i_start;
            o_score_left    <= sl_nxt;
            o_score_right   <= sr_nxt;
            o_winner        <= win_nxt;
            o_serve_dir     <= dir_nxt;
            o_paddle_enable <= state_nxt == SERVE || state_nxt == PLAY;
            o_ball_enable   <= state_nxt == PLAY;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sl_nxt    = o_score_left;
        sr_nxt    = o_score_right;
        win_nxt   = o_winner;
        dir_nxt   = o_serve_dir;
        case (state)
            IDLE, GAME_OVER: ;
            SERVE: begin
                state_nxt = cnt == SERVE_LAST ? PLAY : SERVE;
                cnt_nxt   = cnt == SERVE_LAST ? '0 : cnt + 32'd1;
            end
            PLAY: begin
                cnt_nxt = '0;
                if (i_miss_left && i_miss_right) begin
                    dir_nxt   = ~o_serve_dir;
                    state_nxt = POINT;
                end else if (i_miss_left) begin
                    sr_nxt    = sr_inc;
                    dir_nxt   = 1'b0;
                    state_nxt = sr_inc == WIN ? GAME_OVER : POINT;
                    win_nxt   = sr_inc == WIN ? 2'b10 : 2'b00;
                end else if (i_miss_right) begin
                    sl_nxt    = sl_inc;
                    dir_nxt   = 1'b1;
                    state_nxt = sl_inc == WIN ? GAME_OVER : POINT;
                    win_nxt   = sl_inc == WIN ? 2'b01 : 2'b00;
                end
            end
            POINT: begin
                state_nxt = cnt == POINT_LAST ? SERVE : POINT;
                cnt_nxt   = cnt == POINT_LAST ? '0 : cnt + 32'd1;
            end
            default: state_nxt = IDLE;
        endcase
        // a start press (re)starts the match from any legal state, overriding same-cycle misses
        if (start_edge && state_ok) begin
            state_nxt = SERVE;
            cnt_nxt   = '0;
            sl_nxt    = '0;
            sr_nxt    = '0;
            win_nxt   = 2'b00;
            dir_nxt   = 1'b0;
        end
    end
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed self-checking bench for pong_match_ctrl
module tb_pong_match_ctrl;
    logic       i_Clk = 1'b0;
    logic       i_Rst_n, i_start, i_miss_left, i_miss_right;
    logic       o_paddle_enable, o_ball_enable, o_serve_dir;
    logic [3:0] o_score_left, o_score_right;
    logic [1:0] o_winner;
    logic [2:0] o_state;
    int         n_tests = 0;
    int         n_fail = 0;

    pong_match_ctrl #(
        .SERVE_DELAY_CYCLES(4),
        .POINT_HOLD_CYCLES (3),
        .WIN_SCORE         (3),
        .SCORE_W           (4)
    ) dut (
        .i_Clk          (i_Clk),
        .i_Rst_n        (i_Rst_n),
        .i_start        (i_start),
        .i_miss_left    (i_miss_left),
        .i_miss_right   (i_miss_right),
        .o_paddle_enable(o_paddle_enable),
        .o_ball_enable  (o_ball_enable),
        .o_serve_dir    (o_serve_dir),
        .o_score_left   (o_score_left),
        .o_score_right  (o_score_right),
        .o_winner       (o_winner),
        .o_state        (o_state)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input int st, input int pe, input int be,
                              input int dir, input int sl, input int sr, input int win);
        chk({tag, ".state"}, 32'(o_state), 32'(st));
        chk({tag, ".paddle"}, 32'(o_paddle_enable), 32'(pe));
        chk({tag, ".ball"}, 32'(o_ball_enable), 32'(be));
        chk({tag, ".dir"}, 32'(o_serve_dir), 32'(dir));
        chk({tag, ".sl"}, 32'(o_score_left), 32'(sl));
        chk({tag, ".sr"}, 32'(o_score_right), 32'(sr));
        chk({tag, ".win"}, 32'(o_winner), 32'(win));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    initial begin
        i_Rst_n = 1'b0; i_start = 1'b1; i_miss_left = 1'b0; i_miss_right = 1'b0;
        #1;
        expect_all("reset", 0, 0, 0, 0, 0, 0, 0);
        #22 i_Rst_n = 1'b1;
        tick(2);
        expect_all("held_start", 0, 0, 0, 0, 0, 0, 0);
        i_start = 1'b0; tick(1);
        i_start = 1'b1; tick(1);
        expect_all("press", 1, 1, 0, 0, 0, 0, 0);
        i_start = 1'b0; tick(3);
        expect_all("serve_wait", 1, 1, 0, 0, 0, 0, 0);
        tick(1);
        expect_all("play1", 2, 1, 1, 0, 0, 0, 0);
        i_miss_left = 1'b1; tick(1); i_miss_left = 1'b0;
        expect_all("miss_left", 3, 0, 0, 0, 0, 1, 0);
        tick(2);
        expect_all("point_wait", 3, 0, 0, 0, 0, 1, 0);
        tick(1);
        expect_all("point_serve", 1, 1, 0, 0, 0, 1, 0);
        tick(4);
        expect_all("play2", 2, 1, 1, 0, 0, 1, 0);
        i_miss_right = 1'b1; tick(1); i_miss_right = 1'b0;
        expect_all("mr1", 3, 0, 0, 1, 1, 1, 0);
        tick(7);
        expect_all("play3", 2, 1, 1, 1, 1, 1, 0);
        i_miss_right = 1'b1; tick(1); i_miss_right = 1'b0;
        expect_all("mr2", 3, 0, 0, 1, 2, 1, 0);
        tick(7);
        i_miss_right = 1'b1; tick(1); i_miss_right = 1'b0;
        expect_all("win_left", 4, 0, 0, 1, 3, 1, 1);
        i_miss_left = 1'b1; i_miss_right = 1'b1; tick(1);
        i_miss_left = 1'b0; i_miss_right = 1'b0; tick(2);
        expect_all("gameover_hold", 4, 0, 0, 1, 3, 1, 1);
        i_start = 1'b1; tick(1); i_start = 1'b0;
        expect_all("restart", 1, 1, 0, 0, 0, 0, 0);
        tick(4);
        i_miss_right = 1'b1; tick(1); i_miss_right = 1'b0;
        expect_all("pre_both", 3, 0, 0, 1, 1, 0, 0);
        tick(7);
        i_miss_left = 1'b1; i_miss_right = 1'b1; tick(1);
        i_miss_left = 1'b0; i_miss_right = 1'b0;
        expect_all("both_miss", 3, 0, 0, 0, 1, 0, 0);
        tick(3);
        expect_all("serve3", 1, 1, 0, 0, 1, 0, 0);
        i_miss_left = 1'b1; tick(1); i_miss_left = 1'b0;
        expect_all("serve_ignore", 1, 1, 0, 0, 1, 0, 0);
        tick(3);
        expect_all("play_after_ign", 2, 1, 1, 0, 1, 0, 0);
        i_miss_left = 1'b1; tick(1); i_miss_left = 1'b0;
        expect_all("ml_11", 3, 0, 0, 0, 1, 1, 0);
        i_miss_right = 1'b1; tick(1); i_miss_right = 1'b0;
        expect_all("point_ignore", 3, 0, 0, 0, 1, 1, 0);
        tick(2);
        expect_all("serve4", 1, 1, 0, 0, 1, 1, 0);
        tick(4);
        i_miss_right = 1'b1; tick(1); i_miss_right = 1'b0;
        expect_all("mr_21", 3, 0, 0, 1, 2, 1, 0);
        tick(7);
        expect_all("play_21", 2, 1, 1, 1, 2, 1, 0);
        i_start = 1'b1; i_miss_left = 1'b1; tick(1);
        i_start = 1'b0; i_miss_left = 1'b0;
        expect_all("abort", 1, 1, 0, 0, 0, 0, 0);
        tick(4);
        expect_all("play_pre_rst", 2, 1, 1, 0, 0, 0, 0);
        #3 i_Rst_n = 1'b0;
        #1;
        expect_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        #10 i_Rst_n = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
